// File: rtl/effect_scheduler.sv
// effect_scheduler
//   Round-robin scheduler sharing one effect engine between the left and
//   right audio channels. Each transaction pops one sample from a receive
//   FIFO, either bypasses the engine (sw == 0) or runs it through the
//   engine, then pushes the result into the matching transmit FIFO.
//
//   Optional feature macro: EFFECT_SCHED_TIMEOUT_EN
//     defined   -> watchdog recovers from a stalled engine after
//                  timeout_cycles WAIT cycles, writing the dry sample.
//     undefined -> WAIT waits indefinitely; o_timeout_cnt is tied to 0.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   sw                         effect select, 2'b00 = bypass
//   i_l_ready / i_r_ready      receive FIFO non-empty
//   i_l_data / i_r_data        receive FIFO data, valid the cycle after rd_en
//   o_l_rd_en / o_r_rd_en      one-cycle pop pulse
//   i_l_full / i_r_full        transmit FIFO full
//   o_l_data / o_r_data        transmit write data
//   o_l_wr_en / o_r_wr_en      one-cycle push pulse
//   o_eff_data, o_eff_start    sample and start pulse to the effect engine
//   i_eff_done, i_eff_data     engine completion pulse and result
//   o_busy                     high whenever the FSM is not in IDLE
//   o_timeout_cnt              saturating watchdog-event count
module effect_scheduler #(
  parameter int d_width        = 16,
  parameter int timeout_cycles = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sw,
  input  logic               i_l_ready,
  input  logic               i_r_ready,
  input  logic [d_width-1:0] i_l_data,
  input  logic [d_width-1:0] i_r_data,
  output logic               o_l_rd_en,
  output logic               o_r_rd_en,
  input  logic               i_l_full,
  input  logic               i_r_full,
  output logic [d_width-1:0] o_l_data,
  output logic [d_width-1:0] o_r_data,
  output logic               o_l_wr_en,
  output logic               o_r_wr_en,
  output logic [d_width-1:0] o_eff_data,
  output logic               o_eff_start,
  input  logic               i_eff_done,
  input  logic [d_width-1:0] i_eff_data,
  output logic               o_busy,
  output logic [7:0]         o_timeout_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP   = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] WRITE = 3'd5;

  // Channel encoding: 0 = left, 1 = right.
  logic [2:0]         state_reg, state_next;
  logic               sel_reg;
  logic               last_served_reg;
  logic [1:0]         sw_reg;
  logic [d_width-1:0] sample_reg;
  logic [d_width-1:0] result_reg;

  logic               l_elig, r_elig, any_elig, pick;
  logic               wd_expire;
  logic [d_width-1:0] fifo_data;

  assign l_elig   = i_l_ready && !i_l_full;
  assign r_elig   = i_r_ready && !i_r_full;
  assign any_elig = l_elig || r_elig;
  // Alternate when both are eligible; otherwise take whichever one is.
  assign pick      = (l_elig && r_elig) ? !last_served_reg : r_elig;
  assign fifo_data = sel_reg ? i_r_data : i_l_data;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_elig) state_next = POP;
      POP:     state_next = LATCH;
      LATCH:   state_next = (sw_reg == 2'b00) ? WRITE : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (i_eff_done || wd_expire) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      sel_reg         <= 1'b0;
      last_served_reg <= 1'b1;
      sw_reg          <= 2'b00;
      sample_reg      <= '0;
      result_reg      <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (any_elig) begin
            sel_reg         <= pick;
            last_served_reg <= pick;
          end
        end
        POP: sw_reg <= sw;
        LATCH: begin
          // result_reg doubles as the bypass output; the effect path
          // overwrites it in WAIT.
          sample_reg <= fifo_data;
          result_reg <= fifo_data;
        end
        WAIT: begin
          // done has priority over a coincident watchdog expiry
          if (i_eff_done)
            result_reg <= i_eff_data;
          else if (wd_expire)
            result_reg <= sample_reg;
        end
        default: ;
      endcase
    end
  end

`ifdef EFFECT_SCHED_TIMEOUT_EN
  localparam int wd_w = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  localparam logic [wd_w-1:0] wd_last = wd_w'(timeout_cycles - 1);

  logic [wd_w-1:0] wd_cnt_reg;
  logic [7:0]      timeout_cnt_reg;

  assign wd_expire = (state_reg == WAIT) && (wd_cnt_reg == wd_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg      <= '0;
      timeout_cnt_reg <= 8'd0;
    end else begin
      if (state_reg == ISSUE)
        wd_cnt_reg <= '0;
      else if (state_reg == WAIT)
        wd_cnt_reg <= wd_cnt_reg + 1'b1;

      if (wd_expire && !i_eff_done && timeout_cnt_reg != 8'hFF)
        timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
    end
  end

  assign o_timeout_cnt = timeout_cnt_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (timeout_cycles != 0);
  assign wd_expire     = 1'b0;
  assign o_timeout_cnt = 8'd0;
`endif

  // Per-channel strobes decoded from state and selected channel.
  logic [1:0] rd_en_vec, wr_en_vec;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign rd_en_vec[gi] = (state_reg == POP)   && (sel_reg == gi[0]);
      assign wr_en_vec[gi] = (state_reg == WRITE) && (sel_reg == gi[0]);
    end
  endgenerate

  assign o_l_rd_en   = rd_en_vec[0];
  assign o_r_rd_en   = rd_en_vec[1];
  assign o_l_wr_en   = wr_en_vec[0];
  assign o_r_wr_en   = wr_en_vec[1];
  assign o_l_data    = result_reg;
  assign o_r_data    = result_reg;
  assign o_eff_data  = sample_reg;
  assign o_eff_start = (state_reg == ISSUE);
  assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_effect_scheduler.sv
// Directed testbench for effect_scheduler. Inputs are driven and outputs
// sampled on the falling edge; "cycle 0" is the IDLE cycle in which a
// channel first becomes eligible.
module tb_effect_scheduler;
  localparam int dw = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    sw = 2'b00;
  logic          i_l_ready = 1'b0, i_r_ready = 1'b0;
  logic [dw-1:0] i_l_data = '0, i_r_data = '0;
  logic          o_l_rd_en, o_r_rd_en;
  logic          i_l_full = 1'b0, i_r_full = 1'b0;
  logic [dw-1:0] o_l_data, o_r_data;
  logic          o_l_wr_en, o_r_wr_en;
  logic [dw-1:0] o_eff_data;
  logic          o_eff_start;
  logic          i_eff_done = 1'b0;
  logic [dw-1:0] i_eff_data = '0;
  logic          o_busy;
  logic [7:0]    o_timeout_cnt;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  effect_scheduler #(.d_width(dw), .timeout_cycles(16)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .i_l_ready(i_l_ready), .i_r_ready(i_r_ready),
    .i_l_data(i_l_data), .i_r_data(i_r_data),
    .o_l_rd_en(o_l_rd_en), .o_r_rd_en(o_r_rd_en),
    .i_l_full(i_l_full), .i_r_full(i_r_full),
    .o_l_data(o_l_data), .o_r_data(o_r_data),
    .o_l_wr_en(o_l_wr_en), .o_r_wr_en(o_r_wr_en),
    .o_eff_data(o_eff_data), .o_eff_start(o_eff_start),
    .i_eff_done(i_eff_done), .i_eff_data(i_eff_data),
    .o_busy(o_busy), .o_timeout_cnt(o_timeout_cnt)
  );

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_busy, o_l_rd_en, o_r_rd_en, o_l_wr_en, o_r_wr_en, o_eff_start} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000",
               {o_busy, o_l_rd_en, o_r_rd_en, o_l_wr_en, o_r_wr_en, o_eff_start});
    end
    checks++;
    if ({o_l_data, o_r_data, o_eff_data} !== '0 || o_timeout_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: got l=%h r=%h eff=%h tcnt=%0d want all 0",
               o_l_data, o_r_data, o_eff_data, o_timeout_cnt);
    end
    $display("reset: done");
  endtask

  task automatic test_bypass;
    int starts = 0;
    sw = 2'b00; i_l_data = 16'h1234; i_l_ready = 1'b1;      // cycle 0
    @(negedge clk);                                         // cycle 1
    starts += o_eff_start;
    checks++;
    if (o_l_rd_en !== 1'b1 || o_r_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL bypass_rd: got l=%b r=%b want l=1 r=0", o_l_rd_en, o_r_rd_en);
    end
    i_l_ready = 1'b0;
    @(negedge clk);                                         // cycle 2
    starts += o_eff_start;
    checks++;
    if (o_l_wr_en !== 1'b0 || o_l_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL bypass_c2: got wr=%b rd=%b want 0 0", o_l_wr_en, o_l_rd_en);
    end
    @(negedge clk);                                         // cycle 3
    starts += o_eff_start;
    checks++;
    if (o_l_wr_en !== 1'b1 || o_r_wr_en !== 1'b0 || o_l_data !== 16'h1234) begin
      errors++;
      $display("FAIL bypass_wr: got lwr=%b rwr=%b data=%h want 1 0 1234",
               o_l_wr_en, o_r_wr_en, o_l_data);
    end
    @(negedge clk);                                         // cycle 4
    starts += o_eff_start;
    checks++;
    if (o_busy !== 1'b0 || o_l_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL bypass_idle: got busy=%b wr=%b want 0 0", o_busy, o_l_wr_en);
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL bypass_no_start: got %0d starts want 0", starts);
    end
    $display("bypass: left 1234 written");
  endtask

  task automatic test_effect;
    sw = 2'b01; i_r_data = 16'h00FF; i_r_ready = 1'b1;      // cycle 0
    @(negedge clk);                                         // cycle 1
    checks++;
    if (o_r_rd_en !== 1'b1 || o_l_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL effect_rd: got l=%b r=%b want l=0 r=1", o_l_rd_en, o_r_rd_en);
    end
    i_r_ready = 1'b0;
    @(negedge clk);                                         // cycle 2
    sw = 2'b00;                                             // must not affect this transaction
    @(negedge clk);                                         // cycle 3
    checks++;
    if (o_eff_start !== 1'b1 || o_eff_data !== 16'h00FF) begin
      errors++;
      $display("FAIL effect_start: got start=%b data=%h want 1 00ff", o_eff_start, o_eff_data);
    end
    @(negedge clk);                                         // cycle 4
    checks++;
    if (o_eff_start !== 1'b0 || o_busy !== 1'b1 || o_eff_data !== 16'h00FF || o_r_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL effect_wait4: got start=%b busy=%b data=%h wr=%b want 0 1 00ff 0",
               o_eff_start, o_busy, o_eff_data, o_r_wr_en);
    end
    @(negedge clk);                                         // cycle 5
    checks++;
    if (o_eff_data !== 16'h00FF || o_r_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL effect_wait5: got data=%h wr=%b want 00ff 0", o_eff_data, o_r_wr_en);
    end
    i_eff_done = 1'b1; i_eff_data = 16'h0F0F;
    @(negedge clk);                                         // cycle 6
    i_eff_done = 1'b0;
    checks++;
    if (o_r_wr_en !== 1'b1 || o_l_wr_en !== 1'b0 || o_r_data !== 16'h0F0F) begin
      errors++;
      $display("FAIL effect_wr: got rwr=%b lwr=%b data=%h want 1 0 0f0f",
               o_r_wr_en, o_l_wr_en, o_r_data);
    end
    @(negedge clk);
    $display("effect: right 00ff -> 0f0f");
  endtask

  // Both channels continuously ready from reset: L,R,L,R... every 4 cycles.
  task automatic test_fairness;
    int n = 0;
    int last_c = 0;
    logic exp_r = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sw = 2'b00; i_l_data = 16'h1111; i_r_data = 16'h2222;
    i_l_ready = 1'b1; i_r_ready = 1'b1;                     // cycle 0
    for (int c = 1; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (o_l_wr_en || o_r_wr_en) begin
        checks++;
        if (o_r_wr_en !== exp_r || o_l_wr_en !== !exp_r ||
            o_l_data !== (exp_r ? 16'h2222 : 16'h1111)) begin
          errors++;
          $display("FAIL fair_order[%0d]: got lwr=%b rwr=%b data=%h want right=%b",
                   n, o_l_wr_en, o_r_wr_en, o_l_data, exp_r);
        end
        checks++;
        if (c != ((n == 0) ? 3 : last_c + 4)) begin
          errors++;
          $display("FAIL fair_spacing[%0d]: got cycle %0d want %0d",
                   n, c, (n == 0) ? 3 : last_c + 4);
        end
        $display("fairness: txn %0d %s at cycle %0d", n, o_r_wr_en ? "R" : "L", c);
        last_c = c;
        exp_r = !exp_r;
        n++;
        if (n == 8) begin
          i_l_ready = 1'b0; i_r_ready = 1'b0;
        end
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL fair_count: got %0d writes want 8", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [3:0] exp_seq = 4'b0111;                          // bit n: 1 = right
    i_l_full = 1'b1; i_l_ready = 1'b1; i_r_ready = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (o_l_wr_en || o_r_wr_en) begin
        checks++;
        if (o_r_wr_en !== exp_seq[n] || o_l_wr_en !== !exp_seq[n]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got lwr=%b rwr=%b want right=%b",
                   n, o_l_wr_en, o_r_wr_en, exp_seq[n]);
        end
        $display("backpressure: txn %0d %s", n, o_r_wr_en ? "R" : "L");
        n++;
        if (n == 3) i_l_full = 1'b0;
        if (n == 4) begin
          i_l_ready = 1'b0; i_r_ready = 1'b0;
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d writes want 4", n);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef EFFECT_SCHED_TIMEOUT_EN
  task automatic test_watchdog;
    int early = 0;
    // Engine never answers: dry sample written 16 cycles after WAIT entry.
    sw = 2'b01; i_l_data = 16'hABCD; i_l_ready = 1'b1;     // cycle 0
    @(negedge clk);
    i_l_ready = 1'b0;
    for (int c = 2; c <= 19; c++) begin
      @(negedge clk);
      early += (o_l_wr_en || o_r_wr_en);
    end
    checks++;
    if (early != 0 || o_timeout_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wd_early: got %0d writes tcnt=%0d want 0 0", early, o_timeout_cnt);
    end
    @(negedge clk);                                         // cycle 20
    checks++;
    if (o_l_wr_en !== 1'b1 || o_l_data !== 16'hABCD) begin
      errors++;
      $display("FAIL wd_wr: got wr=%b data=%h want 1 abcd", o_l_wr_en, o_l_data);
    end
    @(negedge clk);
    checks++;
    if (o_timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wd_cnt: got %0d want 1", o_timeout_cnt);
    end
    $display("watchdog: abcd dry after timeout, count %0d", o_timeout_cnt);

    // done coincides with expiry at cycle 19: engine data wins, no count.
    i_r_data = 16'h7777; i_r_ready = 1'b1;                  // cycle 0
    @(negedge clk);
    i_r_ready = 1'b0;
    for (int c = 2; c <= 19; c++) @(negedge clk);
    i_eff_done = 1'b1; i_eff_data = 16'h5A5A;
    @(negedge clk);                                         // cycle 20
    i_eff_done = 1'b0;
    checks++;
    if (o_r_wr_en !== 1'b1 || o_r_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL wd_tie_wr: got wr=%b data=%h want 1 5a5a", o_r_wr_en, o_r_data);
    end
    @(negedge clk);
    checks++;
    if (o_timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wd_tie_cnt: got %0d want 1", o_timeout_cnt);
    end
    $display("watchdog: tie resolved to engine data 5a5a");
  endtask
`endif

  task automatic test_reset_in_wait;
    int stray = 0;
    sw = 2'b01; i_l_data = 16'h4242; i_l_ready = 1'b1;     // cycle 0
    @(negedge clk);
    i_l_ready = 1'b0;
    repeat (4) @(negedge clk);                              // cycle 5, in WAIT
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstw_busy: got %b want 1", o_busy);
    end
    reset = 1'b1;
    @(negedge clk);                                         // cycle 6
    checks++;
    if (o_busy !== 1'b0 || o_l_wr_en !== 1'b0 || o_r_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rstw_idle: got busy=%b lwr=%b rwr=%b want 0 0 0",
               o_busy, o_l_wr_en, o_r_wr_en);
    end
    reset = 1'b0;
    i_eff_done = 1'b1; i_eff_data = 16'hFFFF;               // stray completion
    @(negedge clk);
    i_eff_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      stray += (o_l_wr_en || o_r_wr_en || o_busy);
      @(negedge clk);
    end
    checks++;
    if (stray != 0 || o_l_data !== 16'h0000) begin
      errors++;
      $display("FAIL rstw_stray: got %0d active cycles data=%h want 0 0000", stray, o_l_data);
    end
    $display("reset_in_wait: transaction dropped");
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_effect();
    test_fairness();
    test_backpressure();
`ifdef EFFECT_SCHED_TIMEOUT_EN
    test_watchdog();
`else
    checks++;
    if (o_timeout_cnt !== 8'd0) begin
      errors++;
      $display("FAIL tcnt_tied: got %0d want 0", o_timeout_cnt);
    end
`endif
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end
endmodule
